// File: rtl/usb_dfu_flash_sequencer.sv
// Turns one DFU DNLOAD/UPLOAD block into a single page write/read on the SPI flash bridge,
// metering the exact byte count and reporting done/error to the DFU state logic.
module usb_dfu_flash_sequencer #(
    parameter int          PAGE_SIZE  = 256,
    parameter logic [15:0] BASE_PAGE  = 16'h0000,
    parameter logic [15:0] MAX_BLOCKS = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dnload_start,
    input  logic        upload_start,
    input  logic        abort,
    input  logic [15:0] block_num,
    input  logic [15:0] xfer_len,
    input  logic        out_data_avail,
    output logic        out_data_get,
    input  logic [7:0]  out_data,
    input  logic        in_data_free,
    output logic        in_data_put,
    output logic [7:0]  in_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] flash_address,
    output logic        flash_rd_request,
    output logic        flash_rd_data_free,
    input  logic        flash_rd_data_put,
    input  logic [7:0]  flash_rd_data,
    output logic        flash_wr_request,
    input  logic        flash_wr_busy,
    output logic        flash_wr_data_avail,
    input  logic        flash_wr_data_get,
    output logic [7:0]  flash_wr_data
);

    localparam int          REM_W       = $clog2(PAGE_SIZE + 1);
    localparam logic [15:0] PAGE_SIZE_W = 16'(PAGE_SIZE);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DN_SETUP = 3'd1,
        DN_DATA  = 3'd2,
        DN_DRAIN = 3'd3,
        UP_SETUP = 3'd4,
        UP_DATA  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [REM_W-1:0]  remaining_q, remaining_d;
    logic [15:0]       address_q, address_d;
    logic              aborted_q, aborted_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic rem_nz;
    logic req_zero;
    logic req_bad;
    logic wr_fire;
    logic rd_fire;

    assign rem_nz   = (remaining_q != '0);
    assign req_zero = (xfer_len == 16'd0);
    assign req_bad  = (xfer_len > PAGE_SIZE_W) || (block_num >= MAX_BLOCKS);
    assign wr_fire  = (state_q == DN_DATA) && flash_wr_data_get && rem_nz;
    assign rd_fire  = (state_q == UP_DATA) && flash_rd_data_put && rem_nz;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            address_q   <= '0;
            aborted_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            address_q   <= address_d;
            aborted_q   <= aborted_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        address_d   = address_q;
        aborted_d   = aborted_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // Zero length is the manifest marker and is checked before range errors.
                if (dnload_start || upload_start) begin
                    if (req_zero) begin
                        done_d = 1'b1;
                    end else if (req_bad) begin
                        error_d = 1'b1;
                    end else begin
                        address_d   = BASE_PAGE + block_num;
                        remaining_d = xfer_len[REM_W-1:0];
                        aborted_d   = 1'b0;
                        state_d     = dnload_start ? DN_SETUP : UP_SETUP;
                    end
                end
            end
            DN_SETUP: begin
                if (abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else begin
                    state_d = DN_DATA;
                end
            end
            DN_DATA: begin
                // A page program may already be under way, so abort still waits in drain.
                if (abort) begin
                    state_d     = DN_DRAIN;
                    aborted_d   = 1'b1;
                    remaining_d = '0;
                end else if (wr_fire) begin
                    remaining_d = remaining_q - REM_W'(1);
                    if (remaining_q == REM_W'(1)) begin
                        state_d = DN_DRAIN;
                    end
                end else if (!rem_nz) begin
                    state_d = DN_DRAIN;
                end
            end
            DN_DRAIN: begin
                if (!flash_wr_busy) begin
                    state_d   = IDLE;
                    done_d    = !aborted_q;
                    aborted_d = 1'b0;
                end
            end
            UP_SETUP: begin
                if (abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else begin
                    state_d = UP_DATA;
                end
            end
            UP_DATA: begin
                if (abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (rd_fire) begin
                    remaining_d = remaining_q - REM_W'(1);
                    if (remaining_q == REM_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
                aborted_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        flash_wr_request    = 1'b0;
        flash_wr_data_avail = 1'b0;
        flash_wr_data       = 8'h00;
        out_data_get        = 1'b0;
        flash_rd_request    = 1'b0;
        flash_rd_data_free  = 1'b0;
        in_data_put         = 1'b0;
        in_data             = 8'h00;
        case (state_q)
            DN_DATA: begin
                flash_wr_request    = 1'b1;
                flash_wr_data_avail = out_data_avail && rem_nz;
                out_data_get        = flash_wr_data_get && rem_nz;
                flash_wr_data       = out_data;
            end
            UP_DATA: begin
                flash_rd_request   = 1'b1;
                flash_rd_data_free = in_data_free && rem_nz;
                in_data_put        = flash_rd_data_put && rem_nz;
                in_data            = flash_rd_data;
            end
            default: begin
                flash_wr_request = 1'b0;
            end
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign error         = error_q;
    assign flash_address = address_q;

endmodule

// File: tb/tb_usb_dfu_flash_sequencer.sv
// Bench for usb_dfu_flash_sequencer: models the control endpoint and the flash bridge,
// and compares each transfer against a block-level reference of the DFU request rules.
module tb_usb_dfu_flash_sequencer;

    localparam logic [15:0] BASE  = 16'hFE00;
    localparam int          PAGE  = 256;
    localparam logic [15:0] MAXB  = 16'd1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dnload_start = 1'b0, upload_start = 1'b0, abort = 1'b0;
    logic [15:0] block_num = 16'h0, xfer_len = 16'h0;
    logic        out_data_avail = 1'b0, out_data_get;
    logic [7:0]  out_data = 8'h0;
    logic        in_data_free = 1'b0, in_data_put;
    logic [7:0]  in_data;
    logic        busy, done, error;
    logic [15:0] flash_address;
    logic        flash_rd_request, flash_rd_data_free;
    logic        flash_rd_data_put = 1'b0;
    logic [7:0]  flash_rd_data = 8'h0;
    logic        flash_wr_request, flash_wr_data_avail;
    logic        flash_wr_busy = 1'b0, flash_wr_data_get = 1'b0;
    logic [7:0]  flash_wr_data;

    always #5 clk = ~clk;

    usb_dfu_flash_sequencer #(.PAGE_SIZE(PAGE), .BASE_PAGE(BASE), .MAX_BLOCKS(MAXB)) dut (
        .clk(clk), .reset(reset),
        .dnload_start(dnload_start), .upload_start(upload_start), .abort(abort),
        .block_num(block_num), .xfer_len(xfer_len),
        .out_data_avail(out_data_avail), .out_data_get(out_data_get), .out_data(out_data),
        .in_data_free(in_data_free), .in_data_put(in_data_put), .in_data(in_data),
        .busy(busy), .done(done), .error(error), .flash_address(flash_address),
        .flash_rd_request(flash_rd_request), .flash_rd_data_free(flash_rd_data_free),
        .flash_rd_data_put(flash_rd_data_put), .flash_rd_data(flash_rd_data),
        .flash_wr_request(flash_wr_request), .flash_wr_busy(flash_wr_busy),
        .flash_wr_data_avail(flash_wr_data_avail), .flash_wr_data_get(flash_wr_data_get),
        .flash_wr_data(flash_wr_data)
    );

    int checks = 0;
    int passed = 0;

    // Observations of the most recent transfer
    int          o_done, o_error, o_nbytes, o_bad, o_early, o_bputs, o_rst_bad;
    int          o_fall_idx, o_last_get, o_last_put, o_done_idx;
    bit          o_first_done, o_first_err, o_busy_seen, o_wr_seen, o_rd_seen;
    bit          o_timeout, o_done_req, o_req_after_abort, o_addr_set;
    logic [15:0] o_addr, o_addr_pre;

    function automatic logic [7:0] src_byte(input int n);
        return 8'(n * 13 + 5);
    endfunction

    // Block-level expectation from the request rules alone.
    task automatic ref_model(input logic [15:0] blk, input logic [15:0] len, input int ab,
                             output int e_done, output int e_err, output int e_bytes,
                             output logic [15:0] e_addr, output bit e_req);
        e_done = 0; e_err = 0; e_bytes = 0; e_addr = 16'h0; e_req = 1'b0;
        if (len == 16'd0) begin
            e_done = 1;
        end else if (int'(len) > PAGE || blk >= MAXB) begin
            e_err = 1;
        end else begin
            e_req  = 1'b1;
            e_addr = BASE + blk;
            if (ab >= 0 && ab < int'(len)) begin
                e_bytes = ab;
            end else begin
                e_bytes = int'(len);
                e_done  = 1;
            end
        end
    endtask

    task automatic do_xfer(input bit dn, input bit both, input logic [15:0] blk,
                           input logic [15:0] len, input int abort_at, input int reset_at,
                           input bit stall, input bit toggle_free, input int drain_len,
                           input bit spur);
        int idx = 0, idle = 0, drain = 0, rd_idx = 0, abort_idx = -10;
        bit aborted = 1'b0, did_reset = 1'b0, resetting = 1'b0;
        bit prev_wrbusy = 1'b0, prev_busy = 1'b0, req_prev = 1'b0, req;
        logic [15:0] prev_addr = 16'h0;
        o_done = 0; o_error = 0; o_nbytes = 0; o_bad = 0; o_early = 0; o_bputs = 0;
        o_rst_bad = 0; o_fall_idx = -1; o_last_get = -1; o_last_put = -1; o_done_idx = -1;
        o_first_done = 0; o_first_err = 0; o_busy_seen = 0; o_wr_seen = 0; o_rd_seen = 0;
        o_timeout = 0; o_done_req = 0; o_req_after_abort = 0; o_addr_set = 0;
        o_addr = 16'h0; o_addr_pre = 16'h0;
        @(negedge clk);
        block_num = blk; xfer_len = len;
        dnload_start = dn || both; upload_start = !dn || both;
        @(negedge clk);
        dnload_start = 1'b0; upload_start = 1'b0;
        block_num = 16'($urandom); xfer_len = 16'($urandom);
        while (1) begin
            if (resetting) begin
                reset = 1'b0; resetting = 1'b0;
                if (busy || done || error || flash_wr_request || flash_rd_request ||
                    flash_address != 16'h0 || out_data_get || in_data_put ||
                    flash_wr_data_avail || flash_rd_data_free ||
                    in_data != 8'h0 || flash_wr_data != 8'h0) o_rst_bad++;
            end
            req = flash_wr_request || flash_rd_request;
            if (done) begin
                o_done++; o_done_idx = idx;
                if (idx == 0) o_first_done = 1'b1;
                if (req || busy) o_done_req = 1'b1;
                if (prev_wrbusy) o_early++;
            end
            if (error) begin
                o_error++;
                if (idx == 0) o_first_err = 1'b1;
            end
            if (busy) o_busy_seen = 1'b1;
            if (prev_busy && !busy && dn && !did_reset && prev_wrbusy) o_early++;
            if (flash_wr_request) o_wr_seen = 1'b1;
            if (flash_rd_request) o_rd_seen = 1'b1;
            if (req && !req_prev && !o_addr_set) begin
                o_addr = flash_address; o_addr_pre = prev_addr; o_addr_set = 1'b1;
            end
            if (!req && req_prev) o_fall_idx = idx;
            if (idx == abort_idx + 1 && req) o_req_after_abort = 1'b1;
            if (!busy) idle++; else idle = 0;
            if (idle >= 3 && idx >= 3) break;
            if (idx >= 3000) begin o_timeout = 1'b1; break; end

            abort = 1'b0; dnload_start = 1'b0; upload_start = 1'b0;
            if (abort_at >= 0 && !aborted && o_nbytes == abort_at && req) begin
                abort = 1'b1; aborted = 1'b1; abort_idx = idx;
            end
            if (reset_at >= 0 && !did_reset && o_nbytes == reset_at && req) begin
                reset = 1'b1; did_reset = 1'b1; resetting = 1'b1;
            end
            if (spur && busy && idx == 2) begin
                dnload_start = 1'b1; upload_start = 1'b1;
                block_num = 16'd7; xfer_len = 16'd0;
            end
            if (flash_wr_request) begin
                flash_wr_busy = 1'b1; drain = drain_len;
            end else if (drain > 0) begin
                flash_wr_busy = 1'b1; drain--;
            end else begin
                flash_wr_busy = 1'b0;
            end
            out_data_avail = abort ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            out_data       = src_byte(o_nbytes);
            in_data_free   = abort ? 1'b0 :
                             (toggle_free ? idx[0] : (stall ? 1'($urandom_range(0, 1)) : 1'b1));
            flash_rd_data  = 8'(rd_idx);
            flash_wr_data_get = 1'b0; flash_rd_data_put = 1'b0;
            #1;
            flash_wr_data_get = flash_wr_data_avail && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            flash_rd_data_put = flash_rd_request && flash_rd_data_free &&
                                (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            #1;
            if (out_data_get !== flash_wr_data_get) o_bad++;
            if (flash_wr_data_get) begin
                if (flash_wr_data !== src_byte(o_nbytes)) o_bad++;
                o_nbytes++; o_last_get = idx;
            end
            if (flash_rd_data_put) rd_idx++;
            o_bputs = rd_idx;
            if (in_data_put !== flash_rd_data_put) o_bad++;
            if (in_data_put) begin
                if (in_data !== 8'(o_nbytes)) o_bad++;
                o_nbytes++; o_last_put = idx;
            end
            prev_wrbusy = flash_wr_busy; prev_busy = busy; req_prev = req;
            prev_addr = flash_address;
            idx++;
            @(negedge clk);
        end
        abort = 1'b0; reset = 1'b0; dnload_start = 1'b0; upload_start = 1'b0;
        out_data_avail = 1'b0; in_data_free = 1'b0; flash_wr_busy = 1'b0;
        flash_wr_data_get = 1'b0; flash_rd_data_put = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_data_avail = 1'b1; in_data_free = 1'b1;
        flash_wr_data_get = 1'b1; flash_rd_data_put = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, flash_wr_request, flash_rd_request} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {busy, done, error, flash_wr_request, flash_rd_request});
        else passed++;
        checks++;
        if (flash_address !== 16'h0)
            $display("FAIL reset_addr: got %h want 0000", flash_address);
        else passed++;
        checks++;
        if ({out_data_get, in_data_put, flash_wr_data_avail, flash_rd_data_free} !== 4'b0)
            $display("FAIL reset_passthru: got %b want 0000",
                     {out_data_get, in_data_put, flash_wr_data_avail, flash_rd_data_free});
        else passed++;
        reset = 1'b0;
        out_data_avail = 1'b0; in_data_free = 1'b0;
        flash_wr_data_get = 1'b0; flash_rd_data_put = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dnload_full();
        do_xfer(1'b1, 1'b0, 16'd3, 16'd256, -1, -1, 1'b0, 1'b0, 4, 1'b0);
        checks++;
        if (o_addr !== BASE + 16'd3 || o_addr_pre !== BASE + 16'd3)
            $display("FAIL dn_addr: got %h/%h want %h", o_addr_pre, o_addr, BASE + 16'd3);
        else passed++;
        checks++;
        if (o_nbytes !== 256 || o_bad !== 0)
            $display("FAIL dn_bytes: got %0d bad %0d want 256 bad 0", o_nbytes, o_bad);
        else passed++;
        checks++;
        if (o_fall_idx !== o_last_get + 1)
            $display("FAIL dn_req_fall: got %0d want %0d", o_fall_idx, o_last_get + 1);
        else passed++;
        checks++;
        if (o_done !== 1 || o_done_idx !== o_last_get + 6 || o_early !== 0 || o_done_req)
            $display("FAIL dn_done: got count %0d at %0d early %0d want 1 at %0d early 0",
                     o_done, o_done_idx, o_early, o_last_get + 6);
        else passed++;
        checks++;
        if (o_rd_seen || o_timeout || o_error !== 0)
            $display("FAIL dn_misc: got rd %0d to %0d err %0d want 0 0 0",
                     o_rd_seen, o_timeout, o_error);
        else passed++;
    endtask

    task automatic test_upload();
        do_xfer(1'b0, 1'b0, 16'd0, 16'd64, -1, -1, 1'b0, 1'b1, 0, 1'b0);
        checks++;
        if (o_nbytes !== 64 || o_bputs !== 64 || o_bad !== 0)
            $display("FAIL up_bytes: got %0d puts %0d bad %0d want 64 64 0",
                     o_nbytes, o_bputs, o_bad);
        else passed++;
        checks++;
        if (o_done !== 1 || o_done_idx !== o_last_put + 1 || o_done_req)
            $display("FAIL up_done: got count %0d at %0d req %0d want 1 at %0d req 0",
                     o_done, o_done_idx, o_done_req, o_last_put + 1);
        else passed++;
        checks++;
        if (o_addr !== BASE || o_wr_seen)
            $display("FAIL up_addr: got %h wr %0d want %h wr 0", o_addr, o_wr_seen, BASE);
        else passed++;
        @(negedge clk);
        flash_rd_data = 8'h40; flash_rd_data_put = 1'b1; in_data_free = 1'b1;
        #1;
        checks++;
        if (in_data_put !== 1'b0)
            $display("FAIL up_extra_put: got %b want 0", in_data_put);
        else passed++;
        flash_rd_data_put = 1'b0; in_data_free = 1'b0;
    endtask

    task automatic test_reject();
        do_xfer(1'b1, 1'b0, 16'd0, 16'd257, -1, -1, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if (!o_first_err || o_error !== 1 || o_busy_seen || o_wr_seen || o_rd_seen || o_done !== 0)
            $display("FAIL rej_len: got err %0d/%0d busy %0d req %0d%0d done %0d want 1/1 0 00 0",
                     o_first_err, o_error, o_busy_seen, o_wr_seen, o_rd_seen, o_done);
        else passed++;
        do_xfer(1'b0, 1'b0, MAXB, 16'd16, -1, -1, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if (!o_first_err || o_error !== 1 || o_busy_seen || o_wr_seen || o_rd_seen || o_done !== 0)
            $display("FAIL rej_blk: got err %0d/%0d busy %0d req %0d%0d done %0d want 1/1 0 00 0",
                     o_first_err, o_error, o_busy_seen, o_wr_seen, o_rd_seen, o_done);
        else passed++;
    endtask

    task automatic test_zero_len();
        do_xfer(1'b1, 1'b0, 16'hFFFF, 16'd0, -1, -1, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if (!o_first_done || o_done !== 1 || o_error !== 0 || o_busy_seen || o_wr_seen || o_rd_seen)
            $display("FAIL zero_len: got done %0d/%0d err %0d busy %0d req %0d%0d want 1/1 0 0 00",
                     o_first_done, o_done, o_error, o_busy_seen, o_wr_seen, o_rd_seen);
        else passed++;
    endtask

    task automatic test_abort();
        do_xfer(1'b1, 1'b0, 16'd10, 16'd256, 100, -1, 1'b0, 1'b0, 3, 1'b0);
        checks++;
        if (o_nbytes !== 100 || o_req_after_abort)
            $display("FAIL abort_req: got bytes %0d req %0d want 100 0", o_nbytes, o_req_after_abort);
        else passed++;
        checks++;
        if (o_done !== 0 || o_early !== 0 || o_timeout)
            $display("FAIL abort_drain: got done %0d early %0d to %0d want 0 0 0",
                     o_done, o_early, o_timeout);
        else passed++;
        do_xfer(1'b0, 1'b0, 16'd2, 16'd32, -1, -1, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if (o_done !== 1 || o_nbytes !== 32 || o_bad !== 0)
            $display("FAIL abort_next: got done %0d bytes %0d bad %0d want 1 32 0",
                     o_done, o_nbytes, o_bad);
        else passed++;
    endtask

    task automatic test_reset_mid_upload();
        do_xfer(1'b0, 1'b0, 16'd1, 16'd128, -1, 20, 1'b1, 1'b0, 0, 1'b0);
        checks++;
        if (o_rst_bad !== 0 || o_done !== 0 || o_timeout)
            $display("FAIL rst_mid: got bad %0d done %0d to %0d want 0 0 0",
                     o_rst_bad, o_done, o_timeout);
        else passed++;
        do_xfer(1'b0, 1'b0, 16'd1, 16'd40, -1, -1, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if (o_done !== 1 || o_nbytes !== 40 || o_addr !== BASE + 16'd1)
            $display("FAIL rst_next: got done %0d bytes %0d addr %h want 1 40 %h",
                     o_done, o_nbytes, o_addr, BASE + 16'd1);
        else passed++;
    endtask

    task automatic test_both_starts();
        do_xfer(1'b1, 1'b1, 16'd7, 16'd16, -1, -1, 1'b0, 1'b0, 1, 1'b0);
        checks++;
        if (!o_wr_seen || o_rd_seen || o_done !== 1 || o_nbytes !== 16)
            $display("FAIL both_starts: got wr %0d rd %0d done %0d bytes %0d want 1 0 1 16",
                     o_wr_seen, o_rd_seen, o_done, o_nbytes);
        else passed++;
    endtask

    task automatic test_random();
        bit dn, stall, spur, e_req;
        logic [15:0] blk, len, e_addr;
        int ab, drain, e_done, e_err, e_bytes;
        for (int it = 0; it < 24; it++) begin
            dn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: len = 16'd0;
                1: len = 16'd256;
                2: len = 16'($urandom_range(257, 300));
                default: len = 16'($urandom_range(1, 80));
            endcase
            case ($urandom_range(0, 4))
                0: blk = 16'($urandom_range(1024, 65535));
                1: blk = 16'd1023;
                default: blk = 16'($urandom_range(0, 1023));
            endcase
            stall = 1'($urandom_range(0, 1));
            spur  = 1'($urandom_range(0, 1));
            drain = $urandom_range(0, 5);
            ab = -1;
            if (len != 16'd0 && int'(len) <= PAGE && $urandom_range(0, 3) == 0)
                ab = $urandom_range(0, int'(len) - 1);
            ref_model(blk, len, ab, e_done, e_err, e_bytes, e_addr, e_req);
            do_xfer(dn, 1'b0, blk, len, ab, -1, stall, 1'b0, drain, spur);
            checks++;
            if (o_done !== e_done || o_error !== e_err)
                $display("FAIL rnd%0d_status: got done %0d err %0d want %0d %0d (blk %0d len %0d)",
                         it, o_done, o_error, e_done, e_err, blk, len);
            else passed++;
            checks++;
            if (o_nbytes !== e_bytes || o_bad !== 0 || o_early !== 0 || o_timeout)
                $display("FAIL rnd%0d_bytes: got %0d bad %0d early %0d to %0d want %0d 0 0 0",
                         it, o_nbytes, o_bad, o_early, o_timeout, e_bytes);
            else passed++;
            checks++;
            if (o_addr_set !== e_req || (e_req && o_addr !== e_addr))
                $display("FAIL rnd%0d_addr: got req %0d addr %h want req %0d addr %h",
                         it, o_addr_set, o_addr, e_req, e_addr);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_dnload_full();
        test_upload();
        test_reject();
        test_zero_len();
        test_abort();
        test_reset_mid_upload();
        test_both_starts();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
